mcu_cmd_decoder: RTL and testbench

//  Parametrised successor to the CPLD P2/ALE command decoder. The MCU presents a command code on
//  P2 and pulses ALE while CS is low; this block decodes it into sticky latch outputs
//  (play/rec/9200 chip-selects) and strobe outputs (trst/toneck/comeck/relay clocks).
//  All logic runs on one system clock, and ALE/CS are synchronised into it. It adds timeout,

---
 rtl/mcu_cmd_if.sv | 18 +
 rtl/mcu_cmd_decoder.sv | 100 ++++++++++
 tb/tb_mcu_cmd_decoder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mcu_cmd_if.sv
// mcu_cmd_if: MCU command bus between the P2/ALE master and the command decoder
interface mcu_cmd_if #(
  parameter int ADDR_W     = 4,
  parameter int NUM_LATCH  = 4,
  parameter int NUM_STROBE = 5
);
  logic                  ale;
  logic                  cs;
  logic [ADDR_W-1:0]     p2;
  logic [NUM_LATCH-1:0]  latch_q;
  logic [NUM_STROBE-1:0] strobe_q;
  logic                  cmd_vld;
  logic [ADDR_W-1:0]     cmd_code;
  logic                  cmd_err;
  logic                  strobe_to;
  modport master (output ale, cs, p2, input latch_q, strobe_q, cmd_vld, cmd_code, cmd_err, strobe_to);
  modport slave  (input ale, cs, p2, output latch_q, strobe_q, cmd_vld, cmd_code, cmd_err, strobe_to);
endinterface

// File: rtl/mcu_cmd_decoder.sv
// mcu_cmd_decoder: decodes synchronised P2/ALE commands into sticky latches and timed strobes
module mcu_cmd_decoder #(
  parameter int                   ADDR_W         = 4,
  parameter int                   NUM_LATCH      = 4,
  parameter int                   NUM_STROBE     = 5,
  parameter int                   STROBE_BASE    = 0,
  parameter int                   LATCH_SET_BASE = 5,
  parameter int                   LATCH_CLR_BASE = 9,
  parameter int                   ALL_CLR_CODE   = 15,
  parameter logic [NUM_LATCH-1:0] LATCH_RST_VAL  = 4'b1100,
  parameter int                   STROBE_MAX_CYC = 255,
  parameter int                   SYNC_STAGES    = 2
) (
  input logic      clk,
  input logic      rst_n,
  mcu_cmd_if.slave bus
);
  localparam int TW = $clog2(STROBE_MAX_CYC + 2);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t                              state;
  logic [SYNC_STAGES-1:0]              ale_sh, cs_sh;
  logic [SYNC_STAGES-1:0][ADDR_W-1:0]  p2_sh;
  logic                                ale_d, cs_d;
  logic [TW-1:0]                       timer;
  logic                                ale_s, cs_s, ale_rise, cs_rise, acc;
  logic                                is_all, is_clr, is_set, is_stb, hit, stb_go, timeout;
  logic [ADDR_W-1:0]                   p2_s;
  logic [NUM_LATCH-1:0]                set_mask, clr_mask;
  logic [NUM_STROBE-1:0]               stb_mask;
  assign ale_s    = ale_sh[SYNC_STAGES-1];
  assign cs_s     = cs_sh[SYNC_STAGES-1];
  assign p2_s     = p2_sh[SYNC_STAGES-1];
  assign ale_rise = ale_s & ~ale_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign acc      = ale_rise & ~cs_s;
  for (genvar i = 0; i < NUM_LATCH; i++) begin : g_latch
    assign set_mask[i] = p2_s == ADDR_W'(LATCH_SET_BASE + i);
    assign clr_mask[i] = p2_s == ADDR_W'(LATCH_CLR_BASE + i);
  end
  for (genvar j = 0; j < NUM_STROBE; j++) begin : g_stb
    assign stb_mask[j] = p2_s == ADDR_W'(STROBE_BASE + j);
  end
  assign is_all  = p2_s == ADDR_W'(ALL_CLR_CODE);
  assign is_clr  = |clr_mask;
  assign is_set  = |set_mask;
  assign is_stb  = |stb_mask;
  assign hit     = is_all | is_clr | is_set | is_stb;
  assign stb_go  = acc & is_stb & ~is_all & ~is_clr & ~is_set;
  assign timeout = (STROBE_MAX_CYC != 0) && (state == ACTIVE) && (timer == TW'(STROBE_MAX_CYC - 1));
  // cs/ale sync flops reset to their idle levels so release never fakes an edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ale_sh <= '0;
      cs_sh  <= '1;
      p2_sh  <= '0;
      ale_d  <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      ale_sh <= {ale_sh[SYNC_STAGES-2:0], bus.ale};
      cs_sh  <= {cs_sh[SYNC_STAGES-2:0], bus.cs};
      p2_sh  <= {p2_sh[SYNC_STAGES-2:0], bus.p2};
      ale_d  <= ale_s;
      cs_d   <= cs_s;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      bus.latch_q   <= LATCH_RST_VAL;
      bus.strobe_q  <= '0;
      bus.cmd_vld   <= 1'b0;
      bus.cmd_code  <= '0;
      bus.cmd_err   <= 1'b0;
      bus.strobe_to <= 1'b0;
    end else begin
      bus.cmd_vld   <= acc;
      bus.cmd_err   <= acc & ~hit;
      bus.strobe_to <= timeout;
      if (acc) bus.cmd_code <= p2_s;
      if (acc & is_all) bus.latch_q <= LATCH_RST_VAL;
      else if (acc & is_clr) bus.latch_q <= bus.latch_q & ~clr_mask;
      else if (acc & is_set) bus.latch_q <= bus.latch_q | set_mask;
      // a strobe accept coinciding with timeout keeps only the new bit
      if (acc & is_all) begin
        bus.strobe_q <= '0;
        state        <= IDLE;
        timer        <= '0;
      end else if (stb_go) begin
        bus.strobe_q <= (timeout ? '0 : bus.strobe_q) | stb_mask;
        state        <= ACTIVE;
        timer        <= '0;
      end else if (state == ACTIVE) begin
        if (cs_rise | timeout) begin
          bus.strobe_q <= '0;
          state        <= IDLE;
          timer        <= '0;
        end else timer <= timer + TW'(1);
      end
    end
endmodule

// File: tb/tb_mcu_cmd_decoder.sv
// tb_mcu_cmd_decoder: vector table, directed corner cases and randomized model check
module tb_mcu_cmd_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mcu_cmd_if #(.ADDR_W(4), .NUM_LATCH(4), .NUM_STROBE(5)) bus ();
  mcu_cmd_decoder #(.STROBE_MAX_CYC(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [3:0] code;
    logic       cs;
    logic       vld;
    logic       err;
    logic [3:0] ccode;
    logic [3:0] latch;
    logic [4:0] stb;
  } vec_t;
  vec_t tbl[$];
  int cyc = 0, n_vld = 0, n_err = 0, n_to = 0;
  int total = 0, passed = 0;
  logic [3:0] m_latch;
  logic [4:0] m_stb;
  int m_dead, m_vld, m_err, m_to;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      n_vld += int'(bus.cmd_vld);
      n_err += int'(bus.cmd_err);
      n_to  += int'(bus.strobe_to);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // leaves ale high and returns at the negedge right after the accepting clock edge
  task automatic xact(input logic [3:0] code, input logic csv);
    bus.p2 = code;
    bus.cs = csv;
    repeat (2) @(negedge clk);
    bus.ale = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic do_reset();
    bus.ale = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  // strobes expire 8 edges after the accepting edge; anything accepted on or after that edge sees them cleared
  task automatic model(input logic [3:0] c, input int a, output logic err);
    int k;
    k = int'(c);
    err = 1'b0;
    if (m_dead >= 0 && m_dead <= a) begin
      m_stb = '0;
      m_to++;
      m_dead = -1;
    end
    m_vld++;
    if (k == 15) begin
      m_latch = 4'b1100;
      m_stb = '0;
      m_dead = -1;
    end else if (k >= 9 && k <= 12) m_latch[k-9] = 1'b0;
    else if (k >= 5 && k <= 8) m_latch[k-5] = 1'b1;
    else if (k <= 4) begin
      m_stb = m_stb | (5'b1 << k);
      m_dead = a + 8;
    end else begin
      err = 1'b1;
      m_err++;
    end
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int b_vld, b_err, b_to;
    logic e;
    logic [3:0] c;
    bus.ale = 1'b0;
    bus.cs = 1'b1;
    bus.p2 = '0;
    tbl.push_back(vec_t'{4'd5,  1'b0, 1'b1, 1'b0, 4'd5,  4'b1101, 5'b00000});
    tbl.push_back(vec_t'{4'd9,  1'b0, 1'b1, 1'b0, 4'd9,  4'b1100, 5'b00000});
    tbl.push_back(vec_t'{4'd6,  1'b0, 1'b1, 1'b0, 4'd6,  4'b1110, 5'b00000});
    tbl.push_back(vec_t'{4'd1,  1'b0, 1'b1, 1'b0, 4'd1,  4'b1110, 5'b00010});
    tbl.push_back(vec_t'{4'd3,  1'b0, 1'b1, 1'b0, 4'd3,  4'b1110, 5'b01010});
    tbl.push_back(vec_t'{4'd13, 1'b0, 1'b1, 1'b1, 4'd13, 4'b1110, 5'b01010});
    tbl.push_back(vec_t'{4'd15, 1'b0, 1'b1, 1'b0, 4'd15, 4'b1100, 5'b00000});
    tbl.push_back(vec_t'{4'd7,  1'b0, 1'b1, 1'b0, 4'd7,  4'b1100, 5'b00000});
    tbl.push_back(vec_t'{4'd11, 1'b0, 1'b1, 1'b0, 4'd11, 4'b1000, 5'b00000});
    tbl.push_back(vec_t'{4'd8,  1'b0, 1'b1, 1'b0, 4'd8,  4'b1000, 5'b00000});
    tbl.push_back(vec_t'{4'd12, 1'b0, 1'b1, 1'b0, 4'd12, 4'b0000, 5'b00000});
    tbl.push_back(vec_t'{4'd5,  1'b0, 1'b1, 1'b0, 4'd5,  4'b0001, 5'b00000});
    tbl.push_back(vec_t'{4'd0,  1'b0, 1'b1, 1'b0, 4'd0,  4'b0001, 5'b00001});
    tbl.push_back(vec_t'{4'd4,  1'b0, 1'b1, 1'b0, 4'd4,  4'b0001, 5'b10001});
    tbl.push_back(vec_t'{4'd2,  1'b1, 1'b0, 1'b0, 4'd4,  4'b0001, 5'b00000});
    tbl.push_back(vec_t'{4'd14, 1'b0, 1'b1, 1'b1, 4'd14, 4'b0001, 5'b00000});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_latch", 32'(bus.latch_q), 32'hC);
    chk("rst_strobe", 32'(bus.strobe_q), 32'h0);
    chk("rst_code", 32'(bus.cmd_code), 32'h0);
    repeat (100) @(negedge clk);
    chk("idle_vld_cnt", 32'(n_vld), 32'd0);
    chk("idle_err_cnt", 32'(n_err), 32'd0);
    chk("idle_to_cnt", 32'(n_to), 32'd0);
    chk("idle_latch", 32'(bus.latch_q), 32'hC);
    foreach (tbl[k]) begin
      xact(tbl[k].code, tbl[k].cs);
      chk($sformatf("tbl%0d_vld", k), 32'(bus.cmd_vld), 32'(tbl[k].vld));
      chk($sformatf("tbl%0d_err", k), 32'(bus.cmd_err), 32'(tbl[k].err));
      chk($sformatf("tbl%0d_code", k), 32'(bus.cmd_code), 32'(tbl[k].ccode));
      chk($sformatf("tbl%0d_latch", k), 32'(bus.latch_q), 32'(tbl[k].latch));
      chk($sformatf("tbl%0d_strobe", k), 32'(bus.strobe_q), 32'(tbl[k].stb));
      bus.ale = 1'b0;
    end
    do_reset();
    xact(4'd1, 1'b0);
    bus.ale = 1'b0;
    xact(4'd3, 1'b0);
    bus.ale = 1'b0;
    chk("csr_before", 32'(bus.strobe_q), 32'h0A);
    b_to = n_to;
    bus.cs = 1'b1;
    repeat (2) @(negedge clk);
    chk("csr_sync_hold", 32'(bus.strobe_q), 32'h0A);
    @(negedge clk);
    chk("csr_cleared", 32'(bus.strobe_q), 32'h00);
    chk("csr_no_to", 32'(n_to), 32'(b_to));
    b_to = n_to;
    xact(4'd2, 1'b0);
    bus.ale = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("to_hold%0d", k), 32'(bus.strobe_q), 32'h04);
      @(negedge clk);
    end
    chk("to_cleared", 32'(bus.strobe_q), 32'h00);
    chk("to_pulse", 32'(bus.strobe_to), 32'h1);
    @(negedge clk);
    chk("to_pulse_end", 32'(bus.strobe_to), 32'h0);
    chk("to_count", 32'(n_to - b_to), 32'd1);
    xact(4'd2, 1'b0);
    bus.ale = 1'b0;
    repeat (3) @(negedge clk);
    xact(4'd3, 1'b0);
    bus.ale = 1'b0;
    chk("coin_strobe", 32'(bus.strobe_q), 32'h08);
    chk("coin_to", 32'(bus.strobe_to), 32'h1);
    repeat (12) @(negedge clk);
    xact(4'd0, 1'b0);
    bus.ale = 1'b0;
    xact(4'd6, 1'b0);
    bus.ale = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_latch", 32'(bus.latch_q), 32'hC);
    chk("arst_strobe", 32'(bus.strobe_q), 32'h0);
    chk("arst_code", 32'(bus.cmd_code), 32'h0);
    chk("arst_vld", 32'(bus.cmd_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.cs = 1'b0;
    repeat (4) @(negedge clk);
    m_latch = 4'b1100;
    m_stb = '0;
    m_dead = -1;
    m_vld = 0;
    m_err = 0;
    m_to = 0;
    b_vld = n_vld;
    b_err = n_err;
    b_to = n_to;
    for (int t = 0; t < 300; t++) begin
      c = 4'($urandom_range(0, 15));
      xact(c, 1'b0);
      model(c, cyc, e);
      chk("rnd_vld", 32'(bus.cmd_vld), 32'h1);
      chk("rnd_err", 32'(bus.cmd_err), 32'(e));
      chk("rnd_code", 32'(bus.cmd_code), 32'(c));
      chk("rnd_latch", 32'(bus.latch_q), 32'(m_latch));
      chk("rnd_strobe", 32'(bus.strobe_q), 32'(m_stb));
      bus.ale = 1'b0;
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    if (m_dead >= 0 && m_dead <= cyc) begin
      m_stb = '0;
      m_to++;
      m_dead = -1;
    end
    chk("rnd_final_strobe", 32'(bus.strobe_q), 32'(m_stb));
    chk("rnd_vld_cnt", 32'(n_vld - b_vld), 32'(m_vld));
    chk("rnd_err_cnt", 32'(n_err - b_err), 32'(m_err));
    chk("rnd_to_cnt", 32'(n_to - b_to), 32'(m_to));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
